control_seq: RTL and testbench

Sequential, parametrised successor to the single-cycle control decoder. Sits between FETCH and EX in the RV32 pipeline. Decodes the fetched instruction and registers the control word into the EX stage. It also owns the pipeline's stall and flush sequencing: multi-cycle multiply occupancy, taken-branch/jump bubbles, and a sticky illegal-instruction flag. GPIO CSR writes generalise to N output channels.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_decode.sv | 116 +++++++++++
 rtl/control_seq.sv | 121 ++++++++++++
 tb/tb_control_seq.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the FETCH->EX control path.
// Holds ALU/regsel/state enums, opcode fields, CSR map and the EX control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_ADD   = 4'b0011,
        ALU_SUB   = 4'b0100,
        ALU_MUL   = 4'b0101,
        ALU_MULH  = 4'b0110,
        ALU_MULHU = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1100,
        ALU_SLTU  = 4'b1101
    } aluop_t;

    typedef enum logic [1:0] {
        RS_CSR = 2'b00,
        RS_IMM = 2'b01,
        RS_ALU = 2'b10,
        RS_PC4 = 2'b11
    } regsel_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MUL_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [11:0] CSR_SW        = 12'hF00;
    localparam logic [11:0] CSR_GPIO_BASE = 12'hF02;

    typedef struct packed {
        aluop_t  aluop;
        logic    alusrc;
        regsel_t regsel;
        logic    regwrite;
        logic    is_branch;
        logic    is_jump;
        logic    is_mul;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decoder for the EX control word.
// Unsupported encodings return an all-zero word with illegal_o set.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int N_GPIO = 2
) (
    input  logic [31:0]       instr_i,
    output ctrl_word_t        word_o,
    output logic [N_GPIO-1:0] gpio_we_o,
    output logic              illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] csr;
    logic        unused_bits;

    assign opcode      = instr_i[6:0];
    assign f3          = instr_i[14:12];
    assign f7          = instr_i[31:25];
    assign csr         = instr_i[31:20];
    assign unused_bits = ^{instr_i[19:15], instr_i[11:7]};

    // Map one instruction onto its EX control word and GPIO strobe
    always_comb begin
        word_o    = '0;
        gpio_we_o = '0;
        illegal_o = 1'b0;
        case (opcode)
            OP_R: begin
                word_o.regsel   = RS_ALU;
                word_o.regwrite = 1'b1;
                case ({f7, f3})
                    {F7_BASE, 3'b000}: word_o.aluop = ALU_ADD;
                    {F7_BASE, 3'b001}: word_o.aluop = ALU_SLL;
                    {F7_BASE, 3'b010}: word_o.aluop = ALU_SLT;
                    {F7_BASE, 3'b011}: word_o.aluop = ALU_SLTU;
                    {F7_BASE, 3'b100}: word_o.aluop = ALU_XOR;
                    {F7_BASE, 3'b101}: word_o.aluop = ALU_SRL;
                    {F7_BASE, 3'b110}: word_o.aluop = ALU_OR;
                    {F7_BASE, 3'b111}: word_o.aluop = ALU_AND;
                    {F7_ALT,  3'b000}: word_o.aluop = ALU_SUB;
                    {F7_ALT,  3'b101}: word_o.aluop = ALU_SRA;
                    {F7_MUL,  3'b000}: word_o.aluop = ALU_MUL;
                    {F7_MUL,  3'b001}: word_o.aluop = ALU_MULH;
                    {F7_MUL,  3'b011}: word_o.aluop = ALU_MULHU;
                    default:           illegal_o    = 1'b1;
                endcase
                word_o.is_mul = (f7 == F7_MUL);
            end
            OP_IMM: begin
                word_o.regsel   = RS_ALU;
                word_o.regwrite = 1'b1;
                word_o.alusrc   = 1'b1;
                case (f3)
                    3'b000: word_o.aluop = ALU_ADD;
                    3'b100: word_o.aluop = ALU_XOR;
                    3'b110: word_o.aluop = ALU_OR;
                    3'b111: word_o.aluop = ALU_AND;
                    3'b001: begin
                        word_o.aluop = ALU_SLL;
                        illegal_o    = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     word_o.aluop = ALU_SRL;
                        else if (f7 == F7_ALT) word_o.aluop = ALU_SRA;
                        else                   illegal_o    = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_LUI: begin
                word_o.regsel   = RS_IMM;
                word_o.regwrite = 1'b1;
            end
            OP_BR: begin
                word_o.is_branch = 1'b1;
                case (f3)
                    3'b000, 3'b001: word_o.aluop = ALU_SUB;
                    3'b100, 3'b101: word_o.aluop = ALU_SLT;
                    3'b110, 3'b111: word_o.aluop = ALU_SLTU;
                    default:        illegal_o    = 1'b1;
                endcase
            end
            OP_JAL, OP_JALR: begin
                word_o.aluop    = ALU_ADD;
                word_o.alusrc   = 1'b1;
                word_o.regsel   = RS_PC4;
                word_o.regwrite = 1'b1;
                word_o.is_jump  = 1'b1;
                illegal_o = (opcode == OP_JALR) && (f3 != 3'b000);
            end
            OP_SYS: begin
                for (int i = 0; i < N_GPIO; i++) begin
                    if (csr == CSR_GPIO_BASE + 12'(i)) gpio_we_o[i] = 1'b1;
                end
                if (f3 != F3_CSRRW) begin
                    illegal_o = 1'b1;
                end else if (csr == CSR_SW) begin
                    word_o.regsel   = RS_CSR;
                    word_o.regwrite = 1'b1;
                end else if (gpio_we_o == '0) begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            word_o    = '0;
            gpio_we_o = '0;
        end
    end

endmodule

// File: rtl/control_seq.sv
// control_seq: registered decode into EX plus stall/flush sequencing.
// Owns multiply occupancy, post-jump bubbles and the sticky illegal flag.
module control_seq
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT       = 3,
    parameter int FLUSH_BUBBLES = 1,
    parameter int N_GPIO        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_F,
    input  logic              instr_valid_F,
    input  logic              branch_taken_EX,
    output logic [3:0]        aluop_EX,
    output logic              alusrc_EX,
    output logic [1:0]        regsel_EX,
    output logic              regwrite_EX,
    output logic [N_GPIO-1:0] gpio_we_EX,
    output logic              is_branch_EX,
    output logic              stall_FETCH,
    output logic              flush,
    output logic              illegal
);

    ctrl_word_t        ex_q, ex_d, dec_word;
    logic [N_GPIO-1:0] gpio_q, gpio_d, dec_gpio;
    logic              dec_ill;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ill_q, ill_d;
    logic              flush_c;
    logic              unused_ex;

    ctrl_decode #(.N_GPIO(N_GPIO)) u_dec (
        .instr_i   (instr_F),
        .word_o    (dec_word),
        .gpio_we_o (dec_gpio),
        .illegal_o (dec_ill)
    );

    assign flush_c   = ex_q.is_jump | (ex_q.is_branch & branch_taken_EX);
    assign unused_ex = ex_q.is_mul;

    // Sequence EX loads: decode, hold for multiply, or insert bubbles
    always_comb begin
        ex_d    = ex_q;
        gpio_d  = gpio_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        case (state_q)
            ST_RUN: begin
                if (flush_c) begin
                    ex_d   = '0;
                    gpio_d = '0;
                    // this edge loads the first bubble; cnt owes the rest
                    if (FLUSH_BUBBLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 4'(FLUSH_BUBBLES - 1);
                    end
                end else if (instr_valid_F && !dec_ill) begin
                    ex_d   = dec_word;
                    gpio_d = dec_gpio;
                    if (dec_word.is_mul && MUL_LAT > 1) begin
                        state_d = ST_MUL_WAIT;
                        cnt_d   = 4'(MUL_LAT - 1);
                    end
                end else begin
                    ex_d   = '0;
                    gpio_d = '0;
                    ill_d  = ill_q | instr_valid_F;
                end
            end
            ST_MUL_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            ST_FLUSH: begin
                ex_d   = '0;
                gpio_d = '0;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            default: begin
                ex_d    = '0;
                gpio_d  = '0;
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // EX register, FSM state, counter and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            gpio_q  <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            gpio_q  <= gpio_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign aluop_EX     = ex_q.aluop;
    assign alusrc_EX    = ex_q.alusrc;
    assign regsel_EX    = ex_q.regsel;
    assign regwrite_EX  = ex_q.regwrite;
    assign gpio_we_EX   = gpio_q;
    assign is_branch_EX = ex_q.is_branch;
    assign stall_FETCH  = (state_q == ST_MUL_WAIT);
    assign flush        = flush_c && (state_q == ST_RUN) && !rst;
    assign illegal      = ill_q;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed scenarios plus randomized run against
// an instruction-level reference model of control_seq.
module tb_control_seq;

    localparam int MUL_LAT = 3;
    localparam int FB      = 2;
    localparam int NG      = 2;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_LUI  = 32'h12345037;
    localparam logic [31:0] I_G0   = 32'hF0229073;
    localparam logic [31:0] I_G1   = 32'hF0329073;
    localparam logic [31:0] I_G2   = 32'hF0429073;
    localparam logic [31:0] I_CSW  = 32'hF00010F3;

    typedef struct packed {
        logic [3:0] alu;
        logic       src;
        logic [1:0] sel;
        logic       wr;
        logic [1:0] gpio;
        logic       br;
        logic       jmp;
        logic       mul;
        logic       ill;
    } dec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr_F = '0;
    logic          instr_valid_F = 1'b0;
    logic          branch_taken_EX = 1'b0;
    logic [3:0]    aluop_EX;
    logic          alusrc_EX;
    logic [1:0]    regsel_EX;
    logic          regwrite_EX;
    logic [NG-1:0] gpio_we_EX;
    logic          is_branch_EX;
    logic          stall_FETCH;
    logic          flush;
    logic          illegal;
    logic [13:0]   outs;
    logic [13:0]   exp;
    int            tests = 0;
    int            fails = 0;

    logic [31:0] pool [0:29] = '{
        32'h003100B3, 32'h403100B3, 32'h023100B3, 32'h023110B3,
        32'h023130B3, 32'h023120B3, 32'h003110B3, 32'h003120B3,
        32'h003130B3, 32'h003140B3, 32'h003150B3, 32'h403150B3,
        32'h003160B3, 32'h003170B3, 32'h00510093, 32'h00514093,
        32'h00511093, 32'h40515093, 32'h00512093, 32'h12345037,
        32'h00000463, 32'h00001463, 32'h00004463, 32'h00007463,
        32'h008000EF, 32'h000100E7, 32'hF00010F3, 32'hF0229073,
        32'hF0329073, 32'hF0429073
    };

    control_seq #(
        .MUL_LAT       (MUL_LAT),
        .FLUSH_BUBBLES (FB),
        .N_GPIO        (NG)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_F         (instr_F),
        .instr_valid_F   (instr_valid_F),
        .branch_taken_EX (branch_taken_EX),
        .aluop_EX        (aluop_EX),
        .alusrc_EX       (alusrc_EX),
        .regsel_EX       (regsel_EX),
        .regwrite_EX     (regwrite_EX),
        .gpio_we_EX      (gpio_we_EX),
        .is_branch_EX    (is_branch_EX),
        .stall_FETCH     (stall_FETCH),
        .flush           (flush),
        .illegal         (illegal)
    );

    always #5 clk = ~clk;

    assign outs = {aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, gpio_we_EX,
                   is_branch_EX, stall_FETCH, flush, illegal};

    function automatic logic [13:0] vec(
        input logic [3:0] a, input logic s, input logic [1:0] rs,
        input logic w, input logic [1:0] g, input logic b,
        input logic st, input logic f, input logic il);
        return {a, s, rs, w, g, b, st, f, il};
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t        d;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] csr;
        d   = '0;
        op  = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        csr = i[31:20];
        case (op)
            7'h33: begin
                d.sel = 2'd2;
                d.wr  = 1'b1;
                case ({f7, f3})
                    10'h000: d.alu = 4'h3;
                    10'h001: d.alu = 4'h8;
                    10'h002: d.alu = 4'hC;
                    10'h003: d.alu = 4'hD;
                    10'h004: d.alu = 4'h2;
                    10'h005: d.alu = 4'h9;
                    10'h006: d.alu = 4'h1;
                    10'h007: d.alu = 4'h0;
                    10'h100: d.alu = 4'h4;
                    10'h105: d.alu = 4'hA;
                    10'h008: begin d.alu = 4'h5; d.mul = 1'b1; end
                    10'h009: begin d.alu = 4'h6; d.mul = 1'b1; end
                    10'h00B: begin d.alu = 4'h7; d.mul = 1'b1; end
                    default: d.ill = 1'b1;
                endcase
            end
            7'h13: begin
                d.sel = 2'd2;
                d.wr  = 1'b1;
                d.src = 1'b1;
                case (f3)
                    3'd0: d.alu = 4'h3;
                    3'd4: d.alu = 4'h2;
                    3'd6: d.alu = 4'h1;
                    3'd7: d.alu = 4'h0;
                    3'd1: if (f7 == 7'h00) d.alu = 4'h8; else d.ill = 1'b1;
                    3'd5: begin
                        if (f7 == 7'h00)      d.alu = 4'h9;
                        else if (f7 == 7'h20) d.alu = 4'hA;
                        else                  d.ill = 1'b1;
                    end
                    default: d.ill = 1'b1;
                endcase
            end
            7'h37: begin d.sel = 2'd1; d.wr = 1'b1; end
            7'h63: begin
                d.br = 1'b1;
                if (f3 <= 3'd1)      d.alu = 4'h4;
                else if (f3 <= 3'd3) d.ill = 1'b1;
                else if (f3 <= 3'd5) d.alu = 4'hC;
                else                 d.alu = 4'hD;
            end
            7'h6F, 7'h67: begin
                d.alu = 4'h3; d.src = 1'b1; d.sel = 2'd3;
                d.wr = 1'b1; d.jmp = 1'b1;
                if (op == 7'h67 && f3 != 3'd0) d.ill = 1'b1;
            end
            7'h73: begin
                if (f3 == 3'd1 && csr == 12'hF00) begin
                    d.wr = 1'b1;
                end else if (f3 == 3'd1 && csr >= 12'hF02 &&
                             int'(csr - 12'hF02) < NG) begin
                    d.gpio[csr - 12'hF02] = 1'b1;
                end else begin
                    d.ill = 1'b1;
                end
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d     = '0;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic t);
        instr_F         = i;
        instr_valid_F   = v;
        branch_taken_EX = t;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(I_ADD, 1'b1, 1'b1);
        tick;
        tick;
        exp = '0;
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL reset got=%b exp=%b", outs, exp);
        end
        rst = 1'b0;
        drive('0, 1'b0, 1'b0);
        tick;
    endtask

    task automatic test_add;
        drive(I_ADD, 1'b1, 1'b0);
        tick;
        drive('0, 1'b0, 1'b0);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL add got=%b exp=%b", outs, exp);
        end
    endtask

    task automatic test_mul;
        drive(I_MUL, 1'b1, 1'b0);
        for (int c = 0; c < MUL_LAT; c++) begin
            tick;
            drive(I_ADD, 1'b1, 1'b0);
            exp = vec(4'h5, 0, 2'd2, 1, 2'b00, 0, c < MUL_LAT - 1, 0, 0);
            tests++;
            if (outs !== exp) begin
                fails++;
                $display("FAIL mul_hold c=%0d got=%b exp=%b", c, outs, exp);
            end
        end
        tick;
        drive('0, 1'b0, 1'b0);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL mul_next got=%b exp=%b", outs, exp);
        end
    endtask

    task automatic test_branch;
        drive(I_BEQ, 1'b1, 1'b0);
        tick;
        drive(I_ADD, 1'b1, 1'b1);
        exp = vec(4'h4, 0, 2'd0, 0, 2'b00, 1, 0, 1, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL beq_flush got=%b exp=%b", outs, exp);
        end
        for (int b = 0; b < FB; b++) begin
            tick;
            drive(I_ADD, 1'b1, 1'b1);
            exp = '0;
            tests++;
            if (outs !== exp) begin
                fails++;
                $display("FAIL bubble b=%0d got=%b exp=%b", b, outs, exp);
            end
        end
        tick;
        drive(I_BEQ, 1'b1, 1'b1);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL after_flush got=%b exp=%b", outs, exp);
        end
        tick;
        drive(I_ADD, 1'b1, 1'b0);
        exp = vec(4'h4, 0, 2'd0, 0, 2'b00, 1, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL beq_not_taken got=%b exp=%b", outs, exp);
        end
        tick;
        drive(I_JAL, 1'b1, 1'b0);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL not_taken_next got=%b exp=%b", outs, exp);
        end
        tick;
        drive(I_ADD, 1'b1, 1'b0);
        exp = vec(4'h3, 1, 2'd3, 1, 2'b00, 0, 0, 1, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL jal_flush got=%b exp=%b", outs, exp);
        end
        for (int b = 0; b <= FB; b++) tick;
        drive('0, 1'b0, 1'b0);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL jal_resume got=%b exp=%b", outs, exp);
        end
    endtask

    task automatic test_csr;
        logic [31:0] seq [0:5];
        logic [13:0] want [0:5];
        seq  = '{I_G0, I_G1, I_G2, I_ADD, I_CSW, I_LUI};
        want = '{vec(4'h0, 0, 2'd0, 0, 2'b01, 0, 0, 0, 0),
                 vec(4'h0, 0, 2'd0, 0, 2'b10, 0, 0, 0, 0),
                 vec(4'h0, 0, 2'd0, 0, 2'b00, 0, 0, 0, 1),
                 vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 1),
                 vec(4'h0, 0, 2'd0, 1, 2'b00, 0, 0, 0, 1),
                 vec(4'h0, 0, 2'd1, 1, 2'b00, 0, 0, 0, 1)};
        for (int k = 0; k < 6; k++) begin
            drive(seq[k], 1'b1, 1'b0);
            tick;
            drive('0, 1'b0, 1'b0);
            exp = want[k];
            tests++;
            if (outs !== exp) begin
                fails++;
                $display("FAIL csr k=%0d instr=%h got=%b exp=%b",
                         k, seq[k], outs, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(I_MUL, 1'b1, 1'b0);
        tick;
        rst = 1'b1;
        drive(I_ADD, 1'b1, 1'b0);
        tick;
        rst = 1'b0;
        drive('0, 1'b0, 1'b0);
        exp = '0;
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL reset_mid_mul got=%b exp=%b", outs, exp);
        end
        tick;
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL post_reset_mul got=%b exp=%b", outs, exp);
        end
        drive(I_JAL, 1'b1, 1'b0);
        tick;
        rst = 1'b1;
        drive(I_ADD, 1'b1, 1'b1);
        exp = vec(4'h3, 1, 2'd3, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL rst_masks_flush got=%b exp=%b", outs, exp);
        end
        tick;
        rst = 1'b0;
        drive(I_ADD, 1'b1, 1'b0);
        tick;
        drive('0, 1'b0, 1'b0);
        exp = vec(4'h3, 0, 2'd2, 1, 2'b00, 0, 0, 0, 0);
        tests++;
        if (outs !== exp) begin
            fails++;
            $display("FAIL rst_aborts_flush got=%b exp=%b", outs, exp);
        end
    endtask

    task automatic test_random;
        dec_t        m;
        dec_t        d;
        int          hold;
        int          owe;
        logic        sticky;
        logic        r;
        logic        v;
        logic        tk;
        logic        fl;
        logic [31:0] ins;
        logic [31:0] mask;
        mask = 32'h000F8F80;
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        tick;
        rst = 1'b0;
        m      = '0;
        hold   = 0;
        owe    = 0;
        sticky = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 7) != 0);
            tk = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 9) == 0) ins = $urandom;
            else ins = pool[$urandom_range(0, 29)];
            ins = (ins & ~mask) | ($urandom & mask);
            rst = r;
            drive(ins, v, tk);
            fl  = !r && (m.jmp || (m.br && tk));
            exp = vec(m.alu, m.src, m.sel, m.wr, m.gpio, m.br,
                      hold > 0, fl, sticky);
            tests++;
            if (outs !== exp) begin
                fails++;
                $display("FAIL random n=%0d instr=%h got=%b exp=%b",
                         n, ins, outs, exp);
            end
            if (r) begin
                m = '0; hold = 0; owe = 0; sticky = 1'b0;
            end else if (hold > 0) begin
                hold--;
            end else if (fl) begin
                m   = '0;
                owe = FB - 1;
            end else if (owe > 0) begin
                m = '0;
                owe--;
            end else if (v) begin
                d = ref_decode(ins);
                if (d.ill) begin
                    m      = '0;
                    sticky = 1'b1;
                end else begin
                    m = d;
                    if (d.mul) hold = MUL_LAT - 1;
                end
            end else begin
                m = '0;
            end
            tick;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_add;
        test_mul;
        test_branch;
        test_csr;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
